// File: rtl/srt_pkg.sv
// Shared SRT divide/reconstruct definitions.
// Widths, FSM state encoding and result type.
package srt_pkg;

  localparam int QW = 4;
  localparam int DW = 5;
  localparam int ZW = 9;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_e;

  typedef logic [ZW:0] res_t;

endpackage

// File: rtl/srt_shift_add.sv
// One radix-2 shift-add step of the reconstruction.
// Computes (acc << 1) + (bit ? d : 0).
module srt_shift_add #(
  parameter int DW = 5,
  parameter int AW = 10
) (
  input  logic [AW-1:0] acc_i,
  input  logic [DW-1:0] d_i,
  input  logic          bit_i,
  output logic [AW-1:0] sum_o
);

  logic [AW-1:0] addend;

  // Select the divisor or zero by the current quotient bit.
  always_comb begin
    addend = '0;
    if (bit_i) addend = AW'(d_i);
  end

  assign sum_o = (acc_i << 1) + addend;

endmodule

// File: rtl/srt_recon_mult.sv
// Rebuilds an SRT dividend as z = q*d + s, MSB-first shift-add.
// Define SRT_CHECK_EN to compare the result against z_ref.
module srt_recon_mult #(
  parameter int QW = srt_pkg::QW,
  parameter int DW = srt_pkg::DW,
  parameter int ZW = srt_pkg::ZW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] d,
  input  logic [ZW-1:0] s,
  input  logic [ZW-1:0] z_ref,
  output logic [ZW:0]   z_out,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic          mismatch
);

  import srt_pkg::*;

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic [DW-1:0] d_q, d_d;
  logic [ZW-1:0] s_q, s_d;
  logic [ZW:0]   acc_q, acc_d;
  logic [ZW:0]   z_q, z_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [ZW:0]   step;

  srt_shift_add #(
    .DW(DW),
    .AW(ZW + 1)
  ) u_step (
    .acc_i(acc_q),
    .d_i  (d_q),
    .bit_i(q_q[cnt_q]),
    .sum_o(step)
  );

  // State, operand, accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state: latch, multiply bit by bit, add remainder, publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    s_d     = s_q;
    acc_d   = acc_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = q;
          d_d     = d;
          s_d     = s;
          acc_d   = '0;
          cnt_d   = CW'(QW - 1);
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d   = acc_q + (ZW + 1)'(s_q);
        state_d = DONE;
      end
      DONE: begin
        z_d     = acc_q;
        ovf_d   = acc_q[ZW];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign z_out = z_q;
  assign ovf   = ovf_q;
  assign done  = done_q;
  assign busy  = (state_q == MUL) || (state_q == ADD);

`ifdef SRT_CHECK_EN
  logic [ZW-1:0] zr_q;
  logic          mm_q;

  // Reference capture at start and compare when publishing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zr_q <= '0;
      mm_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) zr_q <= z_ref;
      if (state_q == DONE) mm_q <= (acc_q != {1'b0, zr_q});
    end
  end

  assign mismatch = mm_q;
`else
  logic unused_zref;
  assign unused_zref = ^z_ref;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_srt_recon_mult.sv
// Directed-vector bench for srt_recon_mult.
// Expected values are hand-computed q*d + s.
module tb_srt_recon_mult;

  import srt_pkg::*;

`ifdef SRT_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic [QW-1:0] q     = '0;
  logic [DW-1:0] d     = '0;
  logic [ZW-1:0] s     = '0;
  logic [ZW-1:0] z_ref = '0;
  logic [ZW:0]   z_out;
  logic          ovf;
  logic          busy;
  logic          done;
  logic          mismatch;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  srt_recon_mult dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .q       (q),
    .d       (d),
    .s       (s),
    .z_ref   (z_ref),
    .z_out   (z_out),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done),
    .mismatch(mismatch)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input int qv, input int dv,
                        input int sv, input int rv,
                        input int ez, input int eo,
                        input int em);
    int lat;
    int bc;
    @(negedge clk);
    q     = QW'(qv);
    d     = DW'(dv);
    s     = ZW'(sv);
    z_ref = ZW'(rv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q     = ~q;
    d     = ~d;
    s     = ~s;
    z_ref = ~z_ref;
    lat   = 0;
    bc    = int'(busy);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done) bc += int'(busy);
    end
    chk({tag, ".lat"}, lat, 6);
    chk({tag, ".busy"}, bc, 5);
    chk({tag, ".z"}, int'(z_out), ez);
    chk({tag, ".ovf"}, int'(ovf), eo);
    chk({tag, ".mm"}, int'(mismatch), em);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, int'(done), 0);
    chk({tag, ".hold"}, int'(z_out), ez);
  endtask

  initial begin
    int nd;
    int zc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.z", int'(z_out), 0);
    chk("rst.ovf", int'(ovf), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.mm", int'(mismatch), 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("v8x14", 8, 14, 5, 117, 117, 0, 0);
    run_op("max", 15, 31, 511, 464, 976, 1, CHK);
    run_op("q0", 0, 21, 42, 42, 42, 0, 0);
    run_op("d0", 9, 0, 3, 3, 3, 0, 0);
    run_op("ref116", 8, 14, 5, 116, 117, 0, CHK);

    // Second start two cycles into a busy operation.
    @(negedge clk);
    q     = 4'd8;
    d     = 5'd14;
    s     = 9'd5;
    z_ref = 9'd117;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    q     = 4'd15;
    d     = 5'd31;
    s     = 9'd511;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd    = 0;
    zc    = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        zc = int'(z_out);
      end
    end
    chk("ign.ndone", nd, 1);
    chk("ign.z", zc, 117);

    // Reset during the third MUL cycle after an ovf result.
    run_op("pre", 15, 31, 511, 464, 976, 1, CHK);
    @(negedge clk);
    q     = 4'd8;
    d     = 5'd14;
    s     = 9'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst.z", int'(z_out), 0);
    chk("arst.ovf", int'(ovf), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.done", int'(done), 0);
    chk("arst.mm", int'(mismatch), 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("arst.ndone", nd, 0);

    run_op("post", 5, 7, 1, 36, 36, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
